// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers; one result bit per cycle.
// Optional MDU_DIV0_FLAG_EN adds a div0 output and short-circuits divide-by-zero.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic             div0
`endif
);

    // state | meaning
    // IDLE  | waiting for start; operands latched on start
    // CALC  | one shift-add / restoring-divide step per cycle, WIDTH cycles
    // FIX   | sign correction, HI/LO written on exit
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int                 CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE2     = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        counter;
    logic                 op_r;
    logic                 q_neg;
    logic                 r_neg;
    logic [WIDTH-1:0]     ma;
    logic [WIDTH-1:0]     mb;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 div0_hit;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH+1:0]     diff;
    logic                 unused_diff_bit;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    assign a_neg = sign & a[WIDTH-1];
    assign b_neg = sign & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + ONE) : a;
    assign b_mag = b_neg ? (~b + ONE) : b;

`ifdef MDU_DIV0_FLAG_EN
    assign div0_hit = start & op_div & (b == '0);
`else
    assign div0_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start && !div0_hit) state_next = CALC;
            CALC:    if (counter == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC) || (state == FIX);
    end

    // Divide keeps the remainder in acc[2W-1:W] and the shifting quotient in acc[W-1:0].
    always_comb begin
        sum       = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, ma})
                           : {1'b0, acc[2*WIDTH-1:WIDTH]};
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff      = {1'b0, rem_shift} - {2'b00, mb};
        if (op_r) begin
            acc_next = diff[WIDTH+1] ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

    // A successful subtract always leaves a remainder below the divisor, so bit WIDTH is zero.
    assign unused_diff_bit = diff[WIDTH];

    always_comb begin
        prod_fix = q_neg ? (~acc + ONE2) : acc;
        quo_fix  = q_neg ? (~acc[WIDTH-1:0] + ONE) : acc[WIDTH-1:0];
        rem_fix  = r_neg ? (~acc[2*WIDTH-1:WIDTH] + ONE) : acc[2*WIDTH-1:WIDTH];
        fix_hi   = op_r ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = op_r ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            op_r    <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            ma      <= '0;
            mb      <= '0;
            acc     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_r    <= op_div;
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                        ma      <= a_mag;
                        mb      <= b_mag;
                        counter <= CNT_LAST;
                        acc     <= op_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                        if (div0_hit) done <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (counter != '0) counter <= counter - CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MDU_DIV0_FLAG_EN
    // Divide-by-zero never leaves IDLE: flag and done pulse on the start edge, HI/LO untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            div0 <= 1'b0;
        end else begin
            div0 <= (state == IDLE) && div0_hit;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule
